// File: rtl/dat_mem_arb.sv
// Round-robin arbiter for the shared single-port data memory.
// Ports A (CPU) and B (DMA) may hold ownership for up to MAX_LOCK grants.
module dat_mem_arb #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_e;

  owner_e        owner_q;
  owner_e        owner_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          last_b_q;
  logic          hold_a;
  logic          hold_b;
  logic          cap;
  logic          forced;

  assign hold_a  = (owner_q == OWN_A) && a_req;
  assign hold_b  = (owner_q == OWN_B) && b_req;
  assign cap     = (cnt_q == CW'(MAX_LOCK));
  assign cnt_inc = cap ? cnt_q : cnt_q + CW'(1);

  // Winner selection: live hold first, then round-robin on contention.
  always_comb begin
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    forced = 1'b0;
    if (hold_a) begin
      if (cap && b_req) begin
        b_gnt  = 1'b1;
        forced = 1'b1;
      end else begin
        a_gnt = 1'b1;
      end
    end else if (hold_b) begin
      if (cap && a_req) begin
        a_gnt  = 1'b1;
        forced = 1'b1;
      end else begin
        b_gnt = 1'b1;
      end
    end else if (a_req && b_req) begin
      a_gnt = last_b_q;
      b_gnt = !last_b_q;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_wr_en  = 1'b0;
    mem_dat_in = '0;
    unique case (1'b1)
      a_gnt: begin
        mem_addr   = a_addr;
        mem_wr_en  = a_we;
        mem_dat_in = a_wdata;
      end
      b_gnt: begin
        mem_addr   = b_addr;
        mem_wr_en  = b_we;
        mem_dat_in = b_wdata;
      end
      default: ;
    endcase
  end

  // A forced handover never installs the new winner as owner.
  always_comb begin
    owner_d = OWN_NONE;
    cnt_d   = '0;
    if (a_gnt && a_lock && !forced) begin
      owner_d = OWN_A;
      cnt_d   = (owner_q == OWN_A) ? cnt_inc : CW'(1);
    end else if (b_gnt && b_lock && !forced) begin
      owner_d = OWN_B;
      cnt_d   = (owner_q == OWN_B) ? cnt_inc : CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt) last_b_q <= 1'b0;
      else if (b_gnt) last_b_q <= 1'b1;
      if (a_gnt && !a_we) a_rdata <= mem_dat_out;
      if (b_gnt && !b_we) b_rdata <= mem_dat_out;
    end
  end

endmodule

// File: tb/tb_dat_mem_arb.sv
// Scoreboard bench for dat_mem_arb with a behavioural 256x8 memory.
// Stimulus queues expected grants; a negedge monitor checks them.
module tb_dat_mem_arb;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, a_lock;
  logic [7:0] a_addr, a_wdata;
  logic       b_req, b_we, b_lock;
  logic [7:0] b_addr, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
  logic       mem_wr_en;

  logic [7:0] mem [256];

  typedef struct {
    logic       port;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic       exp_a_rv = 1'b0;
  logic       exp_b_rv = 1'b0;
  logic [7:0] exp_a_dat = '0;
  logic [7:0] exp_b_dat = '0;

  dat_mem_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_lock     (a_lock),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_lock     (b_lock),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .a_gnt      (a_gnt),
    .b_gnt      (b_gnt),
    .a_rvalid   (a_rvalid),
    .b_rvalid   (b_rvalid),
    .a_rdata    (a_rdata),
    .b_rdata    (b_rdata),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_dat_in (mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic p, input logic [7:0] ad,
                      input logic w, input logic [7:0] wd,
                      input logic [7:0] rd);
    exp_t e;
    e.port  = p;
    e.addr  = ad;
    e.we    = w;
    e.wdata = wd;
    e.rdata = rd;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_a_rv = 1'b0;
      exp_b_rv = 1'b0;
    end else begin
      chk("a_rvalid", int'(a_rvalid), int'(exp_a_rv));
      if (exp_a_rv) chk("a_rdata", int'(a_rdata), int'(exp_a_dat));
      chk("b_rvalid", int'(b_rvalid), int'(exp_b_rv));
      if (exp_b_rv) chk("b_rdata", int'(b_rdata), int'(exp_b_dat));
      exp_a_rv = 1'b0;
      exp_b_rv = 1'b0;
      chk("one_hot_gnt", int'(a_gnt && b_gnt), 0);
      if (a_gnt || b_gnt) begin
        if (q.size() == 0) begin
          chk("unexpected_gnt", int'(b_gnt), -1);
        end else begin
          e = q.pop_front();
          chk("gnt_port", int'(b_gnt), int'(e.port));
          chk("mem_addr", int'(mem_addr), int'(e.addr));
          chk("mem_wr_en", int'(mem_wr_en), int'(e.we));
          if (e.we) chk("mem_dat_in", int'(mem_dat_in), int'(e.wdata));
          if (!e.we && !e.port) begin
            exp_a_rv  = 1'b1;
            exp_a_dat = e.rdata;
          end
          if (!e.we && e.port) begin
            exp_b_rv  = 1'b1;
            exp_b_dat = e.rdata;
          end
        end
      end else begin
        chk("idle_wr_en", int'(mem_wr_en), 0);
        chk("idle_addr", int'(mem_addr), 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h3C);
    mem[65] = 8'd30;
    mem[10] = 8'hA1;
    mem[11] = 8'hB2;
    do_reset();

    chk("rst_a_gnt", int'(a_gnt), 0);
    chk("rst_b_gnt", int'(b_gnt), 0);
    chk("rst_a_rvalid", int'(a_rvalid), 0);
    chk("rst_b_rvalid", int'(b_rvalid), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_a_rdata", int'(a_rdata), 0);
    chk("rst_b_rdata", int'(b_rdata), 0);
    tick(2);

    // single A read
    push(0, 65, 0, 0, 30);
    a_req = 1; a_addr = 65;
    tick(1);
    idle();
    tick(2);

    // B write then A read-back
    push(1, 68, 1, 8'h55, 0);
    b_req = 1; b_we = 1; b_addr = 68; b_wdata = 8'h55;
    tick(1);
    idle();
    push(0, 68, 0, 0, 8'h55);
    a_req = 1; a_addr = 68;
    tick(1);
    idle();
    tick(2);

    // continuous contention from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, 65, 0, 0, 30);
      push(1, 68, 0, 0, 8'h55);
    end
    a_req = 1; a_addr = 65;
    b_req = 1; b_addr = 68;
    tick(6);
    idle();
    tick(2);

    // bounded lock: A,A,A,A,B,A,A,A,A,B
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push(1, 11, 0, 0, 8'hB2);
      else push(0, 10, 0, 0, 8'hA1);
    end
    a_req = 1; a_lock = 1; a_addr = 10;
    b_req = 1; b_addr = 11;
    tick(10);
    idle();
    tick(2);

    // owner drops req: B wins immediately
    push(0, 10, 0, 0, 8'hA1);
    push(0, 10, 0, 0, 8'hA1);
    push(1, 11, 0, 0, 8'hB2);
    a_req = 1; a_lock = 1; a_addr = 10;
    tick(2);
    a_req = 0; a_lock = 0;
    b_req = 1; b_addr = 11;
    tick(1);
    idle();
    tick(2);

    // address boundaries
    push(0, 255, 1, 8'hEE, 0);
    a_req = 1; a_we = 1; a_addr = 255; a_wdata = 8'hEE;
    tick(1);
    push(0, 255, 0, 0, 8'hEE);
    a_we = 0; a_wdata = 0;
    tick(1);
    idle();
    push(1, 0, 1, 8'h11, 0);
    b_req = 1; b_we = 1; b_addr = 0; b_wdata = 8'h11;
    tick(1);
    push(1, 0, 0, 0, 8'h11);
    b_we = 0; b_wdata = 0;
    tick(1);
    idle();
    tick(2);

    // reset mid-burst with a read result pending
    push(0, 10, 0, 0, 8'hA1);
    push(0, 10, 0, 0, 8'hA1);
    a_req = 1; a_lock = 1; a_addr = 10;
    tick(2);
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_rvalid", int'(a_rvalid), 0);
    chk("mid_rst_b_rvalid", int'(b_rvalid), 0);
    chk("mid_rst_a_rdata", int'(a_rdata), 0);
    tick(1);
    rst_n = 1'b1;
    push(0, 65, 0, 0, 30);
    push(1, 68, 0, 0, 8'h55);
    a_req = 1; a_lock = 1; a_addr = 65;
    b_req = 1; b_addr = 68;
    tick(1);
    a_req = 0; a_lock = 0;
    tick(1);
    idle();
    tick(3);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dat_mem_arb.md
# dat_mem_arb

Two-requester arbiter that shares the single-port 256x8 data memory between the CPU load/store path (port A) and the DMA/loader path (port B). It sits directly in front of the data memory. It drives the memory's address, write-enable and write-data inputs, and returns registered read data to the winning requester. Arbitration is round-robin. An optional bounded lock lets a requester hold the memory for short read-modify-write bursts.

## Interface
- AW, 8: address width (memory depth 2^AW words)
- DW, 8: data width
- MAX_LOCK, 4: maximum consecutive locked grants to one owner while the other port waits (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_req / b_req  in  1  access request, level, held until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_lock / b_lock  in  1  request to keep ownership after this grant
- a_addr / b_addr  in  AW  word address
- a_wdata / b_wdata  in  DW  write data
- a_gnt / b_gnt  out  1  access performed this cycle (combinational)
- a_rvalid / b_rvalid  out  1  one-cycle pulse, read data valid
- a_rdata / b_rdata  out  DW  registered read data
- mem_addr  out  AW  to memory address
- mem_wr_en  out  1  to memory write enable
- mem_dat_in  out  DW  to memory write data
- mem_dat_out  in  DW  from memory, combinational read data

## Operation
- At most one grant per cycle; a_gnt and b_gnt are never both 1.
- Winner selection, in priority order:
  1. Hold active (owner = X) and X_req=1: grant X. Exception: lock_cnt == MAX_LOCK and the other port is requesting; then grant the other port and clear the hold.
  2. Hold active and X_req=0: hold is released this cycle; fall through to rule 3.
  3. No hold, exactly one request: grant that port.
  4. No hold, both requesting: grant the port not granted last (last_gnt pointer).
- Memory mux:
  - Granted: mem_addr = winner addr; mem_dat_in = winner wdata; mem_wr_en = winner we.
  - Nothing granted: mem_addr=0, mem_dat_in=0, mem_wr_en=0.
- Read: on a granted read, mem_dat_out is captured into that port's rdata at the edge; rvalid=1 the next cycle for one cycle. rdata holds its value until the next read on that port. Writes never pulse rvalid.
- State registers:
  - last_gnt (A/B) is updated on every grant.
  - owner (NONE/A/B) is set to X at the edge when X is granted with X_lock=1 and the grant was not a forced release. Otherwise it is cleared.
  - lock_cnt counts consecutive grants to the owner:
    - Loaded with 1 when owner is set from NONE or from the other port.
    - Incremented on each further grant to the same owner, saturating at MAX_LOCK.
    - Cleared whenever owner is cleared.
- After a forced release, the preempted port competes normally. Its lock is re-honoured only when it next wins.

## Timing
- Grant and memory-side outputs are combinational from req/we/addr/wdata and registered state. Requesters must hold inputs stable while req=1 and not granted.
- Write latency: the memory is written at the same rising edge as the grant cycle.
- Read latency: 1 cycle from grant to rvalid/rdata.
- Back-to-back grants to the same port are allowed every cycle.
- Reset values:
  - last_gnt=B, so A wins the first contention.
  - owner=NONE, lock_cnt=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - mem_wr_en=0 whenever no req.
- Reset asserted mid-burst or mid-read: the hold is dropped and any pending rvalid is lost (forced 0). A grant that was combinational in the cycle reset asserts has no effect on state.
- Boundaries:
  - addr 0 and 2^AW-1 pass through unmodified; no wrap logic.
  - MAX_LOCK=1: every locked grant is preemptible on the next cycle.
  - A locked owner that drops req loses the hold the same cycle, so the other port can win immediately.

## Test plan
- Reset, then idle → all gnt/rvalid=0, mem_wr_en=0, mem_addr=0, a_rdata=b_rdata=0.
- A read addr 65, memory returns 30 → a_gnt=1 and mem_addr=65 same cycle. Next cycle a_rvalid=1, a_rdata=30. b_rvalid stays 0.
- B write addr 68, data 0x55, A idle → b_gnt=1, mem_wr_en=1, mem_addr=68, mem_dat_in=0x55. No rvalid. Subsequent A read of 68 returns 0x55.
- A and B both request reads continuously from reset → grants A,B,A,B,… Each rvalid lands one cycle after that port's grant.
- MAX_LOCK=4, A req+lock held 8 cycles, B req held → grants A,A,A,A,B,A(new lock),A,A. Then B wins again once the renewed lock count hits 4.
- A locked owner with lock_cnt=2, rst_n pulsed low mid-burst → owner=NONE, rvalid=0 immediately. After release, A and B contending → A granted first.
